// File: rtl/board_cell_painter.sv
// Renders one board cell as a raster of single-cycle VGA pixel writes.
// A request latches (row, col, state, cursor); DRAW then emits CELL*CELL pixels.
module board_cell_painter #(
    parameter int ORIGIN_X = 30,
    parameter int ORIGIN_Y = 10,
    parameter int CELL     = 10,
    parameter int GRID     = 10
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_row,
    input  logic [3:0] req_col,
    input  logic [1:0] req_state,
    input  logic       req_cursor,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       err
);

    localparam logic [7:0] LAST   = 8'(CELL - 1);
    localparam logic [4:0] GRID_L = 5'(GRID);

    typedef enum logic {IDLE, DRAW} state_t;

    state_t     fsm, fsm_nxt;
    logic [3:0] row_q, col_q;
    logic [1:0] kind_q;
    logic       cursor_q;
    logic [7:0] dx, dy, dx_nxt, dy_nxt;
    logic       take, ready_nxt, plot_nxt, err_nxt;
    logic [3:0] pix_row, pix_col;
    logic [1:0] pix_kind;
    logic       pix_cursor;
    logic [7:0] x_pix;
    logic [6:0] y_pix;
    logic [2:0] colour_pix;

    function automatic logic [2:0] interior_colour(input logic [1:0] kind);
        case (kind)
            2'd0:    interior_colour = 3'b001;
            2'd1:    interior_colour = 3'b111;
            2'd2:    interior_colour = 3'b100;
            default: interior_colour = 3'b110;
        endcase
    endfunction

    always_comb begin
        fsm_nxt    = fsm;
        dx_nxt     = dx;
        dy_nxt     = dy;
        take       = 1'b0;
        ready_nxt  = 1'b1;
        plot_nxt   = 1'b0;
        err_nxt    = 1'b0;
        pix_row    = row_q;
        pix_col    = col_q;
        pix_kind   = kind_q;
        pix_cursor = cursor_q;
        case (fsm)
            IDLE: begin
                // The first pixel comes straight from the request inputs so it
                // appears in the cycle right after the handshake.
                if (req_valid) begin
                    take       = 1'b1;
                    pix_row    = req_row;
                    pix_col    = req_col;
                    pix_kind   = req_state;
                    pix_cursor = req_cursor;
                    if ({1'b0, req_row} >= GRID_L || {1'b0, req_col} >= GRID_L) begin
                        err_nxt = 1'b1;
                    end else begin
                        fsm_nxt   = DRAW;
                        dx_nxt    = 8'd0;
                        dy_nxt    = 8'd0;
                        plot_nxt  = 1'b1;
                        ready_nxt = 1'b0;
                    end
                end
            end
            DRAW: begin
                if (dx == LAST && dy == LAST) begin
                    fsm_nxt = IDLE;
                end else begin
                    plot_nxt  = 1'b1;
                    ready_nxt = 1'b0;
                    if (dx == LAST) begin
                        dx_nxt = 8'd0;
                        dy_nxt = dy + 8'd1;
                    end else begin
                        dx_nxt = dx + 8'd1;
                    end
                end
            end
            default: fsm_nxt = IDLE;
        endcase

        // 9-bit address arithmetic, truncated to the port widths.
        x_pix = 8'(9'(ORIGIN_X) + 9'(pix_col) * 9'(CELL) + 9'(dx_nxt));
        y_pix = 7'(9'(ORIGIN_Y) + 9'(pix_row) * 9'(CELL) + 9'(dy_nxt));
        if (dx_nxt == 8'd0 || dy_nxt == 8'd0) begin
            colour_pix = pix_cursor ? 3'b010 : 3'b000;
        end else begin
            colour_pix = interior_colour(pix_kind);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            fsm        <= IDLE;
            req_ready  <= 1'b1;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
            vga_plot   <= 1'b0;
            err        <= 1'b0;
        end else begin
            fsm       <= fsm_nxt;
            req_ready <= ready_nxt;
            vga_plot  <= plot_nxt;
            err       <= err_nxt;
            if (plot_nxt) begin
                vga_x      <= x_pix;
                vga_y      <= y_pix;
                vga_colour <= colour_pix;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (take) begin
            row_q    <= req_row;
            col_q    <= req_col;
            kind_q   <= req_state;
            cursor_q <= req_cursor;
        end
        dx <= dx_nxt;
        dy <= dy_nxt;
    end

endmodule

// File: tb/tb_board_cell_painter.sv
// Bench for board_cell_painter: request table plus hand-written timing sequences,
// with a pixel scoreboard filled at each handshake and drained as plots appear.
module tb_board_cell_painter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_row = 4'd0;
    logic [3:0] req_col = 4'd0;
    logic [1:0] req_state = 2'd0;
    logic       req_cursor = 1'b0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       err;

    board_cell_painter dut (
        .CLOCK_50  (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_row   (req_row),
        .req_col   (req_col),
        .req_state (req_state),
        .req_cursor(req_cursor),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .vga_plot  (vga_plot),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; int c;} pix_t;
    typedef struct {int row; int col; int st; int cur; int bad;} vec_t;

    pix_t exp_q[$];
    vec_t vecs[6];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int plot_cnt = 0;
    int err_cnt = 0;
    int hs_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_colour(input int dx, input int dy, input int st, input int cur);
        if (dx == 0 || dy == 0) return cur ? 2 : 0;
        case (st)
            0: return 1;
            1: return 7;
            2: return 4;
            default: return 6;
        endcase
    endfunction

    task automatic push_cell(input int r, input int c, input int st, input int cur);
        pix_t p;
        for (int dy = 0; dy < 10; dy++) begin
            for (int dx = 0; dx < 10; dx++) begin
                p.x = 30 + c * 10 + dx;
                p.y = 10 + r * 10 + dy;
                p.c = model_colour(dx, dy, st, cur);
                exp_q.push_back(p);
            end
        end
    endtask

    // Scoreboard drain: every plot must match the next expected pixel.
    always @(negedge clk) begin
        pix_t e;
        if (rst_n && err) err_cnt++;
        if (rst_n && vga_plot) begin
            plot_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_plot", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pix_x", 32'(vga_x), e.x);
                chk("pix_y", 32'(vga_y), e.y);
                chk("pix_colour", 32'(vga_colour), e.c);
            end
        end
    end

    task automatic send(input int r, input int c, input int st, input int cur, input bit hold);
        int n = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_row    = 4'(r);
        req_col    = 4'(c);
        req_state  = 2'(st);
        req_cursor = cur[0];
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("handshake_timeout", 1, 0);
        if (r < 10 && c < 10) push_cell(r, c, st, cur);
        @(posedge clk);
        @(negedge clk);
        hs_cyc = cyc;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle(output int ready_cyc);
        int n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("idle_timeout", 1, 0);
        ready_cyc = cyc;
    endtask

    initial begin
        int p0, e0, rc, hs1, hs2, n;
        vecs[0] = '{row: 9, col: 9, st: 2, cur: 1, bad: 0};
        vecs[1] = '{row: 10, col: 3, st: 0, cur: 0, bad: 1};
        vecs[2] = '{row: 5, col: 7, st: 3, cur: 0, bad: 0};
        vecs[3] = '{row: 3, col: 15, st: 1, cur: 1, bad: 1};
        vecs[4] = '{row: 4, col: 2, st: 1, cur: 1, bad: 0};
        vecs[5] = '{row: 0, col: 9, st: 0, cur: 1, bad: 0};

        // Reset held for 3 cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_plot", 32'(vga_plot), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_x", 32'(vga_x), 0);
        chk("rst_y", 32'(vga_y), 0);

        // Single water cell with latency and occupancy checks.
        p0 = plot_cnt;
        send(0, 0, 0, 0, 1'b0);
        chk("first_plot_latency", 32'(vga_plot), 1);
        chk("ready_low_in_draw", 32'(req_ready), 0);
        wait_idle(rc);
        chk("ready_return_cycle", 32'(rc - hs_cyc), 100);
        chk("water_plot_count", 32'(plot_cnt - p0), 100);
        chk("water_queue_empty", 32'(exp_q.size()), 0);

        // Request table: valid cells and out-of-range drops.
        for (int i = 0; i < 6; i++) begin
            p0 = plot_cnt;
            e0 = err_cnt;
            send(vecs[i].row, vecs[i].col, vecs[i].st, vecs[i].cur, 1'b0);
            chk("vec_err_pulse", 32'(err), 32'(vecs[i].bad));
            chk("vec_ready_after_hs", 32'(req_ready), 32'(vecs[i].bad));
            repeat (3) @(negedge clk);
            wait_idle(rc);
            repeat (2) @(negedge clk);
            chk("vec_err_cycles", 32'(err_cnt - e0), 32'(vecs[i].bad));
            chk("vec_plot_count", 32'(plot_cnt - p0), vecs[i].bad ? 0 : 100);
            chk("vec_queue_empty", 32'(exp_q.size()), 0);
        end

        // Back-to-back with req_valid held and fields changed mid-draw.
        p0 = plot_cnt;
        send(2, 4, 1, 0, 1'b1);
        hs1 = hs_cyc;
        repeat (30) @(negedge clk);
        req_row = 4'd7; req_col = 4'd1; req_state = 2'd0; req_cursor = 1'b1;
        n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("b2b_timeout", 1, 0);
        push_cell(7, 1, 0, 1);
        @(posedge clk);
        @(negedge clk);
        hs2 = cyc;
        req_valid = 1'b0;
        chk("b2b_handshake_spacing", 32'(hs2 - hs1), 101);
        wait_idle(rc);
        chk("b2b_plot_count", 32'(plot_cnt - p0), 200);
        chk("b2b_queue_empty", 32'(exp_q.size()), 0);

        // Reset after the 50th plot abandons the cell.
        p0 = plot_cnt;
        send(1, 1, 1, 0, 1'b0);
        n = 0;
        while ((plot_cnt - p0) < 50 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("midreset_timeout", 1, 0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_plot", 32'(vga_plot), 0);
        chk("midreset_ready", 32'(req_ready), 1);
        chk("midreset_x", 32'(vga_x), 0);
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        p0 = plot_cnt;
        send(0, 0, 3, 0, 1'b0);
        chk("after_reset_first_x", 32'(vga_x), 30);
        chk("after_reset_first_y", 32'(vga_y), 10);
        wait_idle(rc);
        repeat (3) @(negedge clk);
        chk("after_reset_plot_count", 32'(plot_cnt - p0), 100);
        chk("final_queue_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/board_cell_painter.md
# board_cell_painter

Pixel-stream generator that renders one square cell of the 10x10 battleship board per request. It sits in the same drawing layer as the full-screen clear stage and drives the 160x120, 3-bit-colour VGA adapter pixel-write port (x, y, colour, plot). It converts a high-level "paint cell (row, col, state)" command from game logic into a raster of single-cycle pixel writes.

## Interface

Parameters:
- ORIGIN_X, default 30: screen x of the board's top-left pixel.
- ORIGIN_Y, default 10: screen y of the board's top-left pixel.
- CELL, default 10: cell pitch in pixels, including a 1-pixel border on the top and left.
- GRID, default 10: cells per row and per column.
- Legal parameter sets satisfy ORIGIN_X + GRID*CELL <= 160, ORIGIN_Y + GRID*CELL <= 120 and CELL >= 2.

Ports:
- CLOCK_50, in, 1: sole clock; everything is rising-edge.
- rst_n, in, 1: synchronous, active-low reset, driven from KEY[3] at top level.
- req_valid, in, 1: request present.
- req_ready, out, 1: block can accept a request.
- req_row, in, 4: cell row, 0..GRID-1.
- req_col, in, 4: cell column, 0..GRID-1.
- req_state, in, 2: 0 = water, 1 = ship, 2 = hit, 3 = miss.
- req_cursor, in, 1: draw the border in cursor colour.
- vga_x, out, 8: pixel x.
- vga_y, out, 7: pixel y.
- vga_colour, out, 3: pixel colour, {R,G,B}.
- vga_plot, out, 1: write strobe, one pixel per cycle.
- err, out, 1: one-cycle pulse when an out-of-range request is dropped.

## Operation

- **States:** IDLE and DRAW. On reset the block is in IDLE.
- **Reset values:** req_ready=1, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, err=0.
- **IDLE:**
  - req_ready=1 and vga_plot=0.
  - A handshake is req_valid & req_ready at a rising edge. On a handshake the block latches row, col, state and cursor.
  - If row >= GRID or col >= GRID: err=1 for the next cycle, the block stays in IDLE, req_ready stays 1, and nothing is plotted.
  - Otherwise the block goes to DRAW and clears counters dx=0, dy=0.
- **DRAW:**
  - req_ready=0, and request inputs are ignored.
  - One pixel per cycle in raster order: dx counts 0..CELL-1 as the inner loop, dy counts 0..CELL-1 as the outer loop.
  - vga_x = ORIGIN_X + col*CELL + dx. vga_y = ORIGIN_Y + row*CELL + dy.
  - Address arithmetic is done at 9 bits and then truncated to the port width. The parameter constraints guarantee no overflow.
- **Colour:**
  - Border pixels are those with dx==0 or dy==0. Border colour is 3'b010 (green) if cursor is set, otherwise 3'b000 (black).
  - Interior colour by state: water 3'b001, ship 3'b111, hit 3'b100, miss 3'b110.
- **End of cell:** after the pixel with dx=dy=CELL-1 is emitted, the block returns to IDLE.
- **Non-goals:** the block never overlaps two cells and never plots outside the requested cell.

## Timing

- All outputs are registered.
- Let a handshake occur at edge k:
  - vga_plot=1 during cycles k+1 .. k+CELL*CELL, with the first pixel (dx=0, dy=0) in cycle k+1.
  - req_ready=0 during those same cycles and returns to 1 in cycle k+CELL*CELL+1.
- Throughput is CELL*CELL+1 cycles per cell, i.e. 101 at the defaults. With req_valid held high, the next handshake happens at the edge that ends cycle k+CELL*CELL+1.
- err is high only in cycle k+1, and only for a dropped request.
- **Reset mid-DRAW:** at the first edge with rst_n=0, all outputs go to their reset values and the partial cell is abandoned (not completed). The first request after reset draws from dx=dy=0.
- **req_valid during DRAW:** has no effect and is not queued. The requester must hold it until req_ready=1.

## Test plan

- **Reset:** hold rst_n=0 for 3 cycles, then release -> req_ready=1, vga_plot=0, err=0, vga_x=0, vga_y=0.
- **Single water cell:** request row 0, col 0, water, no cursor at edge k -> 100 plots in cycles k+1..k+100.
  - First pixel (30,10), colour 000.
  - Pixel (31,11), colour 001.
  - Last pixel (39,19), colour 001.
  - req_ready=1 at k+101.
- **Cursor hit cell:** request row 9, col 9, hit, cursor=1 ->
  - Pixels (120..129, 100) and (120, 100..109) have colour 010.
  - Pixel (121,101) has colour 100.
  - Last pixel (129,109).
  - No pixel has x > 129 or y > 109.
- **Out-of-range:** request row 10, col 3 -> err=1 for exactly one cycle, vga_plot stays 0, req_ready stays 1.
- **Back-to-back:** hold req_valid=1 with (2,4,ship) and change the fields mid-draw ->
  - The first cell is drawn entirely with ship colour 111.
  - The second handshake occurs exactly 101 cycles after the first.
- **Reset mid-draw:** assert rst_n=0 after the 50th plot -> vga_plot=0 on the next cycle. A subsequent request (0,0,miss) starts at (30,10) and emits exactly 100 plots.
